// File: rtl/sync_axil_pkg.sv
// Shared types for the synchronizer's AXI4-Lite register slave.
package sync_axil_pkg;

   typedef logic [1:0] axil_resp_t;

   localparam axil_resp_t RESP_OKAY   = 2'b00;
   localparam axil_resp_t RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_HAVE_AW,
      WR_HAVE_W,
      WR_RESP
   } wr_state_t;

   typedef enum logic {
      RD_IDLE,
      RD_RVALID
   } rd_state_t;

endpackage

// File: rtl/sync_axil_reg_slave_if.sv
// AXI4-Lite bus bundle between the master (CPU/VIP) and the register slave.
interface sync_axil_reg_slave_if #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
);
   import sync_axil_pkg::*;

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   axil_resp_t              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   axil_resp_t              rresp;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/sync_axil_reg_slave.sv
// AXI4-Lite control-register slave: NUM_REGS x 32-bit registers with byte strobes,
// registered responses, and per-register write pulses toward the synchronizer core.
module sync_axil_reg_slave
   import sync_axil_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned NUM_REGS   = 4
) (
   input  logic                           S_AXI_ACLK,
   input  logic                           S_AXI_ARESETN,
   sync_axil_reg_slave_if.slave           s_axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   wr_state_t                          wr_state_q;
   rd_state_t                          rd_state_q;
   logic                               awready_q, wready_q, bvalid_q;
   logic                               arready_q, rvalid_q;
   axil_resp_t                         bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0]              rdata_q;
   logic [ADDR_WIDTH-1:0]              awaddr_q;
   logic [DATA_WIDTH-1:0]              wdata_q;
   logic [STRB_W-1:0]                  wstrb_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
   logic [NUM_REGS-1:0]                pulse_q;

   // Commit happens on the edge where the second of AW/W is captured.
   logic                  aw_hs_c, w_hs_c, ar_hs_c;
   logic                  aw_held_c, w_held_c, commit_c;
   logic [ADDR_WIDTH-1:0] wr_addr_c;
   logic [DATA_WIDTH-1:0] wr_data_c;
   logic [STRB_W-1:0]     wr_strb_c;
   logic [IDX_W-1:0]      wr_idx_c, rd_idx_c;
   logic [SEL_W-1:0]      wr_sel_c, rd_sel_c;
   logic                  wr_ok_c, rd_ok_c;
   logic                  unused_c;

   assign aw_hs_c   = s_axi.awvalid & awready_q;
   assign w_hs_c    = s_axi.wvalid & wready_q;
   assign ar_hs_c   = s_axi.arvalid & arready_q;
   assign aw_held_c = aw_hs_c | (wr_state_q == WR_HAVE_AW);
   assign w_held_c  = w_hs_c | (wr_state_q == WR_HAVE_W);
   assign commit_c  = (wr_state_q != WR_RESP) & aw_held_c & w_held_c;

   assign wr_addr_c = (wr_state_q == WR_HAVE_AW) ? awaddr_q : s_axi.awaddr;
   assign wr_data_c = (wr_state_q == WR_HAVE_W) ? wdata_q : s_axi.wdata;
   assign wr_strb_c = (wr_state_q == WR_HAVE_W) ? wstrb_q : s_axi.wstrb;

   assign wr_idx_c = wr_addr_c[ADDR_WIDTH-1:2];
   assign rd_idx_c = s_axi.araddr[ADDR_WIDTH-1:2];
   assign wr_ok_c  = 32'(wr_idx_c) < NUM_REGS;
   assign rd_ok_c  = 32'(rd_idx_c) < NUM_REGS;
   assign wr_sel_c = SEL_W'(wr_idx_c);
   assign rd_sel_c = SEL_W'(rd_idx_c);

   // Protection bits and the sub-word address bits carry no meaning here.
   assign unused_c = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

   // Write channel FSM: independent AW/W capture, then hold B until accepted.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wr_state_q <= WR_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         case (wr_state_q)
            WR_RESP: begin
               if (s_axi.bready) begin
                  wr_state_q <= WR_IDLE;
                  bvalid_q   <= 1'b0;
                  awready_q  <= 1'b1;
                  wready_q   <= 1'b1;
               end
            end
            default: begin
               if (aw_hs_c) awaddr_q <= s_axi.awaddr;
               if (w_hs_c) begin
                  wdata_q <= s_axi.wdata;
                  wstrb_q <= s_axi.wstrb;
               end
               if (commit_c) begin
                  wr_state_q <= WR_RESP;
                  bvalid_q   <= 1'b1;
                  bresp_q    <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
                  awready_q  <= 1'b0;
                  wready_q   <= 1'b0;
               end else if (aw_held_c) begin
                  wr_state_q <= WR_HAVE_AW;
                  awready_q  <= 1'b0;
                  wready_q   <= 1'b1;
               end else if (w_held_c) begin
                  wr_state_q <= WR_HAVE_W;
                  awready_q  <= 1'b1;
                  wready_q   <= 1'b0;
               end else begin
                  wr_state_q <= WR_IDLE;
                  awready_q  <= 1'b1;
                  wready_q   <= 1'b1;
               end
            end
         endcase
      end
   end

   // Register array: byte-lane update and one-cycle write pulse on commit.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         regs_q  <= '0;
         pulse_q <= '0;
      end else begin
         pulse_q <= '0;
         if (commit_c && wr_ok_c) begin
            pulse_q[wr_sel_c] <= 1'b1;
            for (int unsigned b = 0; b < STRB_W; b++) begin
               if (wr_strb_c[b]) regs_q[wr_sel_c][8*b +: 8] <= wr_data_c[8*b +: 8];
            end
         end
      end
   end

   // Read channel FSM: data sampled from the pre-commit register contents.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rd_state_q <= RD_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         case (rd_state_q)
            RD_RVALID: begin
               if (s_axi.rready) begin
                  rd_state_q <= RD_IDLE;
                  rvalid_q   <= 1'b0;
                  arready_q  <= 1'b1;
               end
            end
            default: begin
               if (ar_hs_c) begin
                  rd_state_q <= RD_RVALID;
                  rvalid_q   <= 1'b1;
                  arready_q  <= 1'b0;
                  rdata_q    <= rd_ok_c ? regs_q[rd_sel_c] : '0;
                  rresp_q    <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  arready_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign reg_q         = regs_q;
   assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_sync_axil_reg_slave.sv
// Bench for sync_axil_reg_slave: directed scenarios plus concurrent random traffic,
// checked every cycle against a queue-based transaction model.
module tb_sync_axil_reg_slave;
   import sync_axil_pkg::*;

   localparam int unsigned AW  = 5;
   localparam int unsigned DW  = 32;
   localparam int unsigned NR  = 4;
   localparam int          NRI = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sync_axil_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   logic [NR*32-1:0] reg_q;
   logic [NR-1:0]    reg_wr_pulse;

   sync_axil_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .s_axi         (bus),
      .reg_q         (reg_q),
      .reg_wr_pulse  (reg_wr_pulse)
   );

   int errors = 0;
   int checks = 0;
   int pulse_cnt = 0;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void fail_timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for handshake at %0t", nm, $time);
   endfunction

   // ---------------- behavioural model ----------------
   logic [31:0]      m_reg [NR];
   logic [AW-1:0]    awq [$];
   logic [31:0]      wdq [$];
   logic [3:0]       wsq [$];
   logic             exp_awready, exp_wready, exp_bvalid, exp_arready, exp_rvalid;
   logic [1:0]       exp_bresp, exp_rresp;
   logic [31:0]      exp_rdata;
   logic [NR-1:0]    exp_pulse;
   logic [NR*32-1:0] exp_flat;
   logic             nb, nr;
   logic [NR-1:0]    np;
   logic [AW-1:0]    ma;
   logic [31:0]      md;
   logic [3:0]       ms;
   int               idx;

   always @(negedge clk) begin
      if (!rst_n) begin
         foreach (m_reg[i]) m_reg[i] = '0;
         awq.delete(); wdq.delete(); wsq.delete();
         {exp_awready, exp_wready, exp_bvalid, exp_arready, exp_rvalid} = '0;
         exp_bresp = RESP_OKAY; exp_rresp = RESP_OKAY;
         exp_rdata = '0; exp_pulse = '0;
      end
      for (int i = 0; i < NRI; i++) exp_flat[32*i +: 32] = m_reg[i];
      chk("awready", bus.awready, exp_awready);
      chk("wready",  bus.wready,  exp_wready);
      chk("bvalid",  bus.bvalid,  exp_bvalid);
      chk("bresp",   bus.bresp,   exp_bresp);
      chk("arready", bus.arready, exp_arready);
      chk("rvalid",  bus.rvalid,  exp_rvalid);
      chk("rdata",   bus.rdata,   exp_rdata);
      chk("rresp",   bus.rresp,   exp_rresp);
      chk("reg_q",   reg_q,       exp_flat);
      chk("pulse",   reg_wr_pulse, exp_pulse);
      if (reg_wr_pulse != '0) pulse_cnt += $countones(reg_wr_pulse);

      if (rst_n) begin
         np = '0;
         nb = exp_bvalid;
         if (exp_bvalid && bus.bready) nb = 1'b0;
         if (bus.awvalid && exp_awready) awq.push_back(bus.awaddr);
         if (bus.wvalid && exp_wready) begin
            wdq.push_back(bus.wdata);
            wsq.push_back(bus.wstrb);
         end
         // Reads see the contents as they were before any commit on this edge.
         nr = exp_rvalid;
         if (exp_rvalid && bus.rready) nr = 1'b0;
         if (!exp_rvalid && bus.arvalid && exp_arready) begin
            idx = int'(bus.araddr[AW-1:2]);
            nr = 1'b1;
            exp_rdata = (idx < NRI) ? m_reg[idx] : 32'h0;
            exp_rresp = (idx < NRI) ? RESP_OKAY : RESP_SLVERR;
         end
         if (awq.size() > 0 && wdq.size() > 0) begin
            ma = awq.pop_front(); md = wdq.pop_front(); ms = wsq.pop_front();
            idx = int'(ma[AW-1:2]);
            if (idx < NRI) begin
               for (int b = 0; b < 4; b++) if (ms[b]) m_reg[idx][8*b +: 8] = md[8*b +: 8];
               np[idx] = 1'b1;
               exp_bresp = RESP_OKAY;
            end else begin
               exp_bresp = RESP_SLVERR;
            end
            nb = 1'b1;
         end
         exp_bvalid  = nb;
         exp_rvalid  = nr;
         exp_arready = !nr;
         exp_awready = !nb && awq.size() == 0;
         exp_wready  = !nb && wdq.size() == 0;
         exp_pulse   = np;
      end
   end

   // ---------------- drivers (called at posedge + 1) ----------------
   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
      bit done;
      resp = 2'bxx;
      fork
         begin
            bit ok = 0;
            if (aw_dly > 0) begin repeat (aw_dly) @(posedge clk); #1; end
            bus.awaddr = a; bus.awprot = 3'($urandom); bus.awvalid = 1'b1;
            for (int n = 0; n < 200 && !ok; n++) begin
               @(negedge clk); if (bus.awready) ok = 1;
               @(posedge clk); #1;
            end
            if (!ok) fail_timeout("aw");
            bus.awvalid = 1'b0;
         end
         begin
            bit ok = 0;
            if (w_dly > 0) begin repeat (w_dly) @(posedge clk); #1; end
            bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
            for (int n = 0; n < 200 && !ok; n++) begin
               @(negedge clk); if (bus.wready) ok = 1;
               @(posedge clk); #1;
            end
            if (!ok) fail_timeout("w");
            bus.wvalid = 1'b0;
         end
      join
      done = 0;
      if (b_dly < 0) begin
         for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk); if (bus.bvalid) begin done = 1; resp = bus.bresp; end
            @(posedge clk); #1;
         end
         if (!done) fail_timeout("b_hold");
      end else begin
         if (b_dly > 0) begin repeat (b_dly) @(posedge clk); #1; end
         bus.bready = 1'b1;
         for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk); if (bus.bvalid) begin done = 1; resp = bus.bresp; end
            @(posedge clk); #1;
         end
         if (!done) fail_timeout("b");
         bus.bready = 1'b0;
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int r_dly,
                          output logic [31:0] d, output logic [1:0] resp);
      bit ok = 0;
      d = 'x; resp = 2'bxx;
      bus.araddr = a; bus.arprot = 3'($urandom); bus.arvalid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk); if (bus.arready) ok = 1;
         @(posedge clk); #1;
      end
      if (!ok) fail_timeout("ar");
      bus.arvalid = 1'b0;
      if (r_dly > 0) begin repeat (r_dly) @(posedge clk); #1; end
      bus.rready = 1'b1;
      ok = 0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk); if (bus.rvalid) begin ok = 1; d = bus.rdata; resp = bus.rresp; end
         @(posedge clk); #1;
      end
      if (!ok) fail_timeout("r");
      bus.rready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   logic [1:0]  resp;
   logic [31:0] rd;
   int          pc0;

   initial begin
      rst_n = 1'b0;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      #200;
      @(posedge clk); #1;
      chk("rst_awready", bus.awready, 1'b0);
      chk("rst_reg_q", reg_q, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_cycle_arready", bus.arready, 1'b0);
      @(posedge clk); #1;
      chk("rise_arready", bus.arready, 1'b1);

      // Basic write then read-back of every register.
      for (int i = 0; i < 4; i++) begin
         do_write(AW'(4*i), 32'(i + 1), 4'hF, 0, 0, 0, resp);
         chk("t1_bresp", resp, RESP_OKAY);
      end
      for (int i = 0; i < 4; i++) begin
         do_read(AW'(4*i), 0, rd, resp);
         chk("t1_rdata", rd, 32'(i + 1));
         chk("t1_rresp", resp, RESP_OKAY);
      end
      chk("t1_pulses", pulse_cnt, 4);

      // AW ahead of W, then W ahead of AW.
      do_write(AW'(4), 32'h55, 4'hF, 0, 3, 0, resp);
      do_write(AW'(4), 32'h66, 4'hF, 3, 0, 0, resp);
      do_read(AW'(4), 0, rd, resp);
      chk("t2_rdata", rd, 32'h66);

      // Byte strobes.
      do_write(AW'(0), 32'hAABBCCDD, 4'hF, 0, 0, 0, resp);
      do_write(AW'(0), 32'h11223344, 4'b0101, 0, 0, 0, resp);
      do_read(AW'(0), 0, rd, resp);
      chk("t3_rdata", rd, 32'hAA22CC44);

      // Back-pressure on B and R.
      do_write(AW'(8), 32'hDEADBEEF, 4'hF, 0, 0, 10, resp);
      do_read(AW'(8), 10, rd, resp);
      chk("t4_rdata", rd, 32'hDEADBEEF);

      // Out-of-range index and empty strobe.
      pc0 = pulse_cnt;
      do_write(AW'(5'h10), 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp);
      chk("t5_bresp", resp, RESP_SLVERR);
      do_read(AW'(5'h10), 0, rd, resp);
      chk("t5_rdata", rd, 32'h0);
      chk("t5_rresp", resp, RESP_SLVERR);
      chk("t5_pulses", pulse_cnt, pc0);
      do_write(AW'(5'h0C), 32'h0, 4'h0, 0, 0, 0, resp);
      chk("t5_strb0_bresp", resp, RESP_OKAY);
      chk("t5_strb0_pulse", pulse_cnt, pc0 + 1);
      do_read(AW'(5'h0D), 0, rd, resp);
      chk("t5_strb0_keep", rd, 32'h4);

      // Concurrent random traffic on both channels.
      fork
         for (int k = 0; k < 150; k++) begin
            logic [1:0] r;
            do_write(AW'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r);
         end
         for (int k = 0; k < 150; k++) begin
            logic [1:0]  r;
            logic [31:0] x;
            do_read(AW'($urandom), int'($urandom_range(0, 3)), x, r);
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
         end
      join

      // Reset while a response is pending.
      do_write(AW'(5'h0C), 32'h12345678, 4'hF, 0, 0, -1, resp);
      chk("t6_pre_bvalid", bus.bvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_bvalid_drop", bus.bvalid, 1'b0);
      chk("t6_regs_clear", reg_q, '0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_wready_low", bus.wready, 1'b0);
      @(posedge clk); #1;
      chk("t6_awready_up", bus.awready, 1'b1);
      do_write(AW'(5'h04), 32'hCAFEF00D, 4'hF, 0, 0, 0, resp);
      do_read(AW'(5'h04), 0, rd, resp);
      chk("t6_after_rdata", rd, 32'hCAFEF00D);
      do_read(AW'(5'h0C), 0, rd, resp);
      chk("t6_cleared_reg", rd, 32'h0);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
